// File: rtl/mem_stage_ws.sv
// mem_stage_ws: EX/MEM pipeline register with an on-chip word memory and an
// optional fixed wait-state stall for loads and stores.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   *E inputs         execute-stage controls, address (AluOutE), store data,
//                     destination register, access size and load signedness
//   FlushM            bubble insert at a capture edge
//   RegWriteM         registered write-back enable, low while MemBusy
//   MemtoRegM         registered load select
//   AluOutM           registered ALU result / byte address
//   RD                extended load data read from the addressed word
//   WriteRegM         registered destination register
//   MemBusy           stall request, high for WAIT_CYC cycles per memory op
//   MisalignM         misaligned-access flag (MEM_MISALIGN_TRAP_EN builds only)
//
// Build option: define MEM_MISALIGN_TRAP_EN to add MisalignM and suppress
// misaligned accesses; otherwise misaligned low address bits are ignored.
module mem_stage_ws #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic [1:0]        MemSizeE,
  input  logic              MemSignedE,
  input  logic [DATA_W-1:0] AluOutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [4:0]        WriteRegE,
  input  logic              FlushM,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic [DATA_W-1:0] AluOutM,
  output logic [DATA_W-1:0] RD,
  output logic [4:0]        WriteRegM,
  output logic              MemBusy
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              MisalignM
`endif
);

  localparam int unsigned WORDS = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic [1:0]        size;
    logic              sgn;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        wreg;
  } pipe_t;

  pipe_t             pipe_q, pipe_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              rwm_q, rwm_d;
  logic              mis_q, mis_d;

  logic [DATA_W-1:0] mem_q [WORDS];

  logic [ADDR_W-1:0] widx_c;
  logic [1:0]        lane_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] wr_word_c;
  logic [DATA_W-1:0] rd_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic              we_c;

  // Capture, flush, wait-state FSM and gated write-back enable.
  always_comb begin
    pipe_d  = pipe_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;

    if (!busy_q) begin
      pipe_d.regwrite = RegWriteE & ~FlushM;
      pipe_d.memtoreg = MemtoRegE & ~FlushM;
      pipe_d.memwrite = MemWriteE & ~FlushM;
      pipe_d.size     = MemSizeE;
      pipe_d.sgn      = MemSignedE;
      pipe_d.alu      = AluOutE;
      pipe_d.wdata    = WriteDataE;
      pipe_d.wreg     = WriteRegE;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_d = (MemtoRegE | MemWriteE) & ~FlushM &
              (((MemSizeE == 2'b01) & AluOutE[0]) |
               (MemSizeE[1] & (AluOutE[1:0] != 2'b00)));
`else
      mis_d = 1'b0;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if ((MemtoRegE | MemWriteE) && !FlushM && (WAIT_CYC != 0)) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(WAIT_CYC);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WAIT);
    rwm_d  = pipe_d.regwrite & ~busy_d & ~mis_d;
  end

  // Lane selection for loads and read-modify-write merge for stores.
  always_comb begin
    widx_c    = pipe_q.alu[ADDR_W+1:2];
    lane_c    = pipe_q.alu[1:0];
    rd_word_c = mem_q[widx_c];
    byte_c    = rd_word_c[{lane_c, 3'b000} +: 8];
    half_c    = rd_word_c[{lane_c[1], 4'b0000} +: 16];
    wr_word_c = rd_word_c;
    rd_c      = rd_word_c;

    case (pipe_q.size)
      2'b00: begin
        wr_word_c[{lane_c, 3'b000} +: 8] = pipe_q.wdata[7:0];
        rd_c = pipe_q.sgn ? {{(DATA_W-8){byte_c[7]}}, byte_c}
                          : {{(DATA_W-8){1'b0}}, byte_c};
      end
      2'b01: begin
        wr_word_c[{lane_c[1], 4'b0000} +: 16] = pipe_q.wdata[15:0];
        rd_c = pipe_q.sgn ? {{(DATA_W-16){half_c[15]}}, half_c}
                          : {{(DATA_W-16){1'b0}}, half_c};
      end
      default: begin
        wr_word_c = pipe_q.wdata;
        rd_c      = rd_word_c;
      end
    endcase

    // Single commit edge: right after capture, or the edge that leaves WAIT.
    if (WAIT_CYC == 0) begin
      we_c = pipe_q.memwrite & ~mis_q;
    end else begin
      we_c = pipe_q.memwrite & ~mis_q & (state_q == S_WAIT) & (cnt_q == CNT_W'(1));
    end
  end

  // Pipeline, FSM and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q  <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rwm_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pipe_q  <= pipe_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rwm_q   <= rwm_d;
      mis_q   <= mis_d;
    end
  end

  // Data memory, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(WORDS); i++) mem_q[i] <= '0;
    end else if (we_c) begin
      mem_q[widx_c] <= wr_word_c;
    end
  end

  assign RegWriteM = rwm_q;
  assign MemtoRegM = pipe_q.memtoreg;
  assign AluOutM   = pipe_q.alu;
  assign WriteRegM = pipe_q.wreg;
  assign MemBusy   = busy_q;
  assign RD        = rd_c;
`ifdef MEM_MISALIGN_TRAP_EN
  assign MisalignM = mis_q;
`endif

endmodule

// File: doc/mem_stage_ws.md
MEM_STAGE_WS -- requirements
Module: mem_stage_ws

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data/address path width; only 32 is legal.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning word-address bits; memory holds 2^ADDR_W words.
REQ-003 SHALL have parameter WAIT_CYC, default 0, meaning memory wait states per load/store; legal range 0..15.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock in the block.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports RegWriteE, MemtoRegE, MemWriteE  input  1 each  execute-stage control bits.
REQ-007 SHALL have port MemSizeE  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-008 SHALL have port MemSignedE  input  1  load sign-extend enable, for byte/half only.
REQ-009 SHALL have ports AluOutE, WriteDataE  input  DATA_W each  byte address and store data.
REQ-010 SHALL have port WriteRegE  input  5  destination register.
REQ-011 SHALL have port FlushM  input  1  synchronous bubble insert.
REQ-012 SHALL have ports RegWriteM, MemtoRegM  output  1 each  registered control; RegWriteM is gated by ~MemBusy.
REQ-013 SHALL have ports AluOutM, RD  output  DATA_W each  registered ALU result and extended load data.
REQ-014 SHALL have port WriteRegM  output  5  registered destination.
REQ-015 SHALL have port MemBusy  output  1  stall request to the hazard unit; high while in WAIT.

Function
REQ-016 Pipeline register capture SHALL occur only on a clock edge where MemBusy=0; it SHALL hold all fields while MemBusy=1.
REQ-017 FlushM=1 at a capture edge SHALL load RegWrite/MemtoReg/MemWrite=0 and keep data fields; FlushM SHALL be ignored while MemBusy=1.
REQ-018 FSM states SHALL be IDLE and WAIT.
REQ-019 In IDLE, capturing (MemtoRegE|MemWriteE)=1 with WAIT_CYC>0 and no flush SHALL go to WAIT with cnt=WAIT_CYC.
REQ-020 In WAIT, cnt SHALL decrement each cycle; on the edge where cnt==1 the FSM SHALL return to IDLE.
REQ-021 MemBusy SHALL therefore be high for exactly WAIT_CYC cycles per memory op; WAIT_CYC=0 SHALL never assert MemBusy.
REQ-022 Store write SHALL happen on exactly one edge: the first edge after capture if WAIT_CYC=0, else the edge leaving WAIT.
REQ-023 Word index SHALL be AluOutM[ADDR_W+1:2]; higher address bits are ignored (wrap-around).
REQ-024 Byte lanes SHALL be little-endian: byte lane = addr[1:0], half lane = addr[1].
REQ-025 Stores SHALL write only the enabled lanes: SB the low byte of WriteData, SH the low half, SW the full word.
REQ-026 Loads SHALL read combinationally from the stored word and select the lane.
REQ-027 Loads SHALL zero-extend, or sign-extend when MemSignedM=1, to DATA_W.
REQ-028 RD SHALL be valid whenever MemBusy=0.
REQ-029 A load following a store to the same word SHALL return the new data.

Reset
REQ-030 rst=0 SHALL asynchronously clear all pipeline fields, the FSM (to IDLE), cnt and MemBusy to 0, and every memory word to 0.
REQ-031 Reset mid-WAIT SHALL abort the access, with no store committed unless its commit edge already occurred.
REQ-032 Reset release SHALL take effect on the next clk edge.

Configuration
REQ-033 Macro MEM_MISALIGN_TRAP_EN, when defined, SHALL add output MisalignM (1 bit, reset 0).
REQ-034 With MEM_MISALIGN_TRAP_EN, MisalignM=1 SHALL flag a half access with addr[0]=1 or a word access with addr[1:0]!=0.
REQ-035 With MEM_MISALIGN_TRAP_EN, a flagged access SHALL suppress the store and force RegWriteM=0; WAIT timing SHALL be unchanged.
REQ-036 Without MEM_MISALIGN_TRAP_EN, MisalignM SHALL not exist, and offending low address bits SHALL be ignored (forced alignment).

Verification
REQ-037 WAIT_CYC=0: SW 0x8000_00F0 to addr 0x10, then LW 0x10 -> RD=0x8000_00F0 the cycle after the load is captured, and MemBusy stays 0.
REQ-038 Word 0x14 holds 0xAABB_CCDD: LB addr 0x15 signed -> RD=0xFFFF_FFCC; LBU -> 0x0000_00CC; LH addr 0x16 signed -> 0xFFFF_AABB.
REQ-039 SB 0x55 to addr 0x17 over 0x1122_3344 -> word reads 0x5522_3344.
REQ-040 WAIT_CYC=3: LW captured -> MemBusy high 3 cycles, RegWriteM=0 during them, then 1 for one cycle; E inputs changed during the stall are not captured.
REQ-041 FlushM with SW 0xDEAD_BEEF to addr 0x20 -> memory at 0x20 unchanged and MemBusy never asserted.
REQ-042 rst pulsed low during cycle 2 of WAIT on a SW -> word unchanged, MemBusy=0 immediately; MEM_MISALIGN_TRAP_EN build: LW addr 0x21 -> MisalignM=1, RegWriteM=0.
